bs_down_timer: RTL
==================

Name: bs_down_timer

Overview:
- Loadable 16-bit down-counter/timer; the counting counterpart of the up-counter bs_counter.
- Software or control logic loads a start value, gates counting with Enable, and receives a one-cycle Done pulse on expiry.
- Optional auto-reload gives periodic ticks.
- Used as the CPU's delay/timeout and periodic-tick source.

Parameters:
- WIDTH, 16, counter and load-value width.

Ports:
- clk  input  1  system clock, rising-edge active
- clr  input  1  reset, asynchronous, active-high
- Enable  input  1  count-gate; decrement allowed only when high
- Load  input  1  synchronous load strobe
- Din  input  WIDTH  start/reload value captured on Load
- AutoReload  input  1  on expiry: reload from stored value (1) or stop at zero (0)
- Q  output  WIDTH  current count, registered
- Zero  output  1  combinational, (Q == 0)
- Busy  output  1  registered, high while state == RUN
- Done  output  1  registered one-cycle expiry pulse

Interface: one clock (clk); reset is asynchronous and active-high (clr).

Behaviour:
- Reset (clr=1, any time, including mid-count): Q=0, reload register R=0, state=IDLE, Busy=0, Done=0. All outputs hold these values while clr is high.
- States: IDLE, RUN. Busy is registered as (next state == RUN), so it is valid in the same cycle as Q.
- Done defaults to 0 every cycle unless set by a terminal decrement.
- Priority per rising edge: Load > terminal decrement > normal decrement > hold.
- Load=1, any state:
  - R<=Din and Q<=Din.
  - If Din!=0, state<=RUN; if Din==0, state<=IDLE.
  - Done<=0, even when it coincides with a terminal decrement.
  - Enable is ignored in that cycle.
- RUN, Load=0, Enable=0: Q and state hold. Pause is unlimited.
- RUN, Load=0, Enable=1, Q>1: Q<=Q-1.
- RUN, Load=0, Enable=1, Q==1 (terminal decrement): Done<=1.
  - AutoReload=1: Q<=R and state stays RUN. R is nonzero by construction.
  - AutoReload=0: Q<=0 and state<=IDLE.
- IDLE, Load=0: Q holds and Enable is ignored. No underflow or wrap below zero is ever produced.
- AutoReload is sampled only at the terminal decrement, so it may change freely mid-count.
- Latency:
  - Load to Q valid: 1 clock.
  - Start value N with continuous Enable: Done is high in the edge-N cycle, coincident with Q becoming 0 (or R).
  - Period with auto-reload: N cycles.
- Arithmetic: unsigned WIDTH-bit. Max load is 2^WIDTH-1; no carry/borrow outputs.
- Zero is combinational from Q only. Zero and Done are both high in a non-reload expiry cycle.

Decomposition:
- Shared package (cpu_pkg):
  - WIDTH default (16).
  - State encoding constants ST_IDLE=1'b0, ST_RUN=1'b1.
- No sub-module: a single always block for the state/Q/R/Done registers plus one continuous assign for Zero.

Test Plan:
- Reset mid-count: Load Din=5, run 2 cycles (Q=3), assert clr asynchronously between edges -> Q=0, Busy=0, Done=0 immediately without waiting for a clock edge.
- One-shot: Load Din=3, AutoReload=0, Enable=1 continuously -> Q = 3, 2, 1, 0 on successive edges; Done=1 only in the Q=0 cycle; Busy falls with it; Q stays 0 for 4 further enabled cycles.
- Pause: Load Din=6, Enable pattern 1,1,0,0,1 -> Q = 6, 5, 4, 4, 4, 3; Busy=1 throughout; Done=0.
- Auto-reload: Load Din=4, AutoReload=1, Enable=1 for 12 cycles -> Done pulses exactly at cycles 4, 8 and 12; Q sequence 4,3,2,1,4,3,2,1,4 etc.; Busy stays 1.
- Load vs. terminal collision: Q=1, Enable=1, Load=1 with Din=9 on the same edge -> Q=9, Done=0, Busy=1.
- Zero load: Load Din=0 while RUN at Q=7 -> Q=0, state IDLE, Busy=0, Zero=1, Done=0; subsequent Enable has no effect.

Source files
------------

// File: rtl/bs_down_timer_pkg.sv
// Shared definitions for the loadable down-counter/timer.
// Default counter width and FSM state encoding.
package bs_down_timer_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/bs_down_timer_if.sv
// Control/status bundle of the down-timer. The master drives the controls,
// and the slave (the timer) returns the count and the status flags.
interface bs_down_timer_if
    import bs_down_timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             Enable;
    logic             Load;
    logic [WIDTH-1:0] Din;
    logic             AutoReload;
    logic [WIDTH-1:0] Q;
    logic             Zero;
    logic             Busy;
    logic             Done;

    modport master (
        output Enable, Load, Din, AutoReload,
        input  Q, Zero, Busy, Done
    );

    modport slave (
        input  Enable, Load, Din, AutoReload,
        output Q, Zero, Busy, Done
    );
endinterface

// File: rtl/bs_down_timer.sv
// Loadable WIDTH-bit down-timer. It gives a one-cycle Done pulse on expiry and
// can reload itself to produce periodic ticks. WIDTH must match the interface.
module bs_down_timer
    import bs_down_timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  clr,
    bs_down_timer_if.slave        tmr
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            done_q  <= done_d;
        end
    end

    // Priority: Load, then terminal decrement, then normal decrement, then hold.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        done_d  = 1'b0;
        if (tmr.Load) begin
            r_d     = tmr.Din;
            q_d     = tmr.Din;
            state_d = (tmr.Din != '0) ? ST_RUN : ST_IDLE;
        end else if (state_q == ST_RUN && tmr.Enable) begin
            if (q_q > WIDTH'(1)) begin
                q_d = q_q - WIDTH'(1);
            end else begin
                // A RUN state always holds a nonzero count, so this is the Q==1 expiry.
                done_d = 1'b1;
                if (tmr.AutoReload) begin
                    q_d = r_q;
                end else begin
                    q_d     = '0;
                    state_d = ST_IDLE;
                end
            end
        end
    end

    assign tmr.Q    = q_q;
    assign tmr.Zero = (q_q == '0);
    assign tmr.Busy = (state_q == ST_RUN);
    assign tmr.Done = done_q;

endmodule
